// File: rtl/mac_operand_join.sv
// mac_operand_join: joins A/B operand streams into {a,b} beats via a small FIFO, tags group ends and counts finished groups
module mac_operand_join #(
   parameter int p_width = 16,
   parameter int p_depth = 4,
   parameter int p_group = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           a_val,
   output logic                           a_rdy,
   input  logic [p_width-1:0]             a_msg,
   input  logic                           b_val,
   output logic                           b_rdy,
   input  logic [p_width-1:0]             b_msg,
   output logic                           req_val,
   input  logic                           req_rdy,
   output logic [2*p_width-1:0]           req_msg,
   output logic                           req_last,
   output logic [$clog2(p_depth+1)-1:0]   count,
   output logic [15:0]                    groups_sent
);
   localparam int aw = $clog2(p_depth);
   localparam int cw = $clog2(p_depth+1);
   localparam int gw = p_group > 1 ? $clog2(p_group) : 1;
   logic [2*p_width:0] mem_q [p_depth];
   logic [2*p_width:0] head;
   logic [aw-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [cw-1:0] cnt_q, cnt_d;
   logic [gw-1:0] grp_q, grp_d;
   logic [15:0] groups_q, groups_d;
   logic full, enq, deq, tag_last;
   assign head = mem_q[rd_q];
   assign full = cnt_q == cw'(p_depth);
   assign tag_last = grp_q == gw'(p_group-1);
   // every output is masked while reset is low so nothing handshakes during reset
   assign a_rdy = reset & b_val & !full;
   assign b_rdy = reset & a_val & !full;
   assign enq = a_rdy & a_val;
   assign req_val = reset & (cnt_q != '0);
   assign req_msg = reset ? head[2*p_width-1:0] : '0;
   assign req_last = reset & head[2*p_width];
   assign deq = req_val & req_rdy;
   assign count = reset ? cnt_q : '0;
   assign groups_sent = reset ? groups_q : '0;
   always_comb begin
      wr_d = wr_q + aw'(enq);
      rd_d = rd_q + aw'(deq);
      cnt_d = cnt_q + cw'(enq) - cw'(deq);
      grp_d = !enq ? grp_q : tag_last ? '0 : grp_q + gw'(1);
      groups_d = groups_q + 16'(deq & head[2*p_width]);
   end
   always_ff @(posedge clk) begin
      if (enq) mem_q[wr_q] <= {tag_last, a_msg, b_msg};
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
         grp_q <= '0;
         groups_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         cnt_q <= cnt_d;
         grp_q <= grp_d;
         groups_q <= groups_d;
      end
   end
endmodule

// File: tb/tb_mac_operand_join.sv
// tb_mac_operand_join: directed and randomly throttled checks of the A/B operand join FIFO
module tb_mac_operand_join;
   logic clk = 0, reset = 0, a_val = 0, b_val = 0, req_rdy = 0;
   logic [15:0] a_msg = 0, b_msg = 0;
   logic a_rdy, b_rdy, req_val, req_last;
   logic [31:0] req_msg;
   logic [2:0] count;
   logic [15:0] groups_sent;
   int errors = 0, checks = 0;
   logic [15:0] va [4] = '{16'd5, 16'd2, 16'd4, 16'd2};
   logic [15:0] vb [4] = '{16'd10, 16'd4, 16'd8, 16'd1};
   logic [31:0] vexp [4] = '{32'h0005000A, 32'h00020004, 32'h00040008, 32'h00020001};
   logic [32:0] q [$];
   logic [32:0] e;

   mac_operand_join dut (
      .clk(clk), .reset(reset),
      .a_val(a_val), .a_rdy(a_rdy), .a_msg(a_msg),
      .b_val(b_val), .b_rdy(b_rdy), .b_msg(b_msg),
      .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg), .req_last(req_last),
      .count(count), .groups_sent(groups_sent)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 0; a_val = 0; b_val = 0; req_rdy = 0;
      tick;
      tick;
      reset = 1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_a_rdy"}, 32'(a_rdy), 0);
      chk({tag, "_b_rdy"}, 32'(b_rdy), 0);
      chk({tag, "_req_val"}, 32'(req_val), 0);
      chk({tag, "_req_msg"}, req_msg, 0);
      chk({tag, "_req_last"}, 32'(req_last), 0);
      chk({tag, "_count"}, 32'(count), 0);
      chk({tag, "_groups"}, 32'(groups_sent), 0);
   endtask

   initial begin
      int sent, recv, cyc, sz;
      logic fire;
      // reset with both streams offered
      reset = 0; a_val = 1; b_val = 1; req_rdy = 1; a_msg = 16'h1234; b_msg = 16'h5678;
      tick;
      chk_zero("rst");
      // directed MAC vectors
      reset = 1;
      for (int i = 0; i < 4; i++) begin
         a_val = 1; b_val = 1; a_msg = va[i]; b_msg = vb[i];
         tick;
         chk("dir_val", 32'(req_val), 1);
         chk("dir_msg", req_msg, vexp[i]);
         chk("dir_last", 32'(req_last), 32'(i == 3));
      end
      a_val = 0; b_val = 0;
      tick;
      chk("dir_groups", 32'(groups_sent), 1);
      chk("dir_count", 32'(count), 0);
      chk("dir_empty", 32'(req_val), 0);
      // skewed streams
      do_reset;
      a_val = 1; b_val = 0; a_msg = 16'h00aa; b_msg = 16'h00bb;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("skew_b_rdy", 32'(b_rdy), 1);
         chk("skew_a_rdy", 32'(a_rdy), 0);
         tick;
      end
      chk("skew_count0", 32'(count), 0);
      b_val = 1;
      #1;
      chk("skew_a_rdy3", 32'(a_rdy), 1);
      tick;
      a_val = 0; b_val = 0;
      chk("skew_count", 32'(count), 1);
      chk("skew_msg", req_msg, 32'h00aa00bb);
      // full
      do_reset;
      for (int k = 0; k < 4; k++) begin
         a_val = 1; b_val = 1; a_msg = 16'(k + 1); b_msg = 16'(k + 16);
         tick;
      end
      chk("full_count", 32'(count), 4);
      a_msg = 16'd5; b_msg = 16'd20;
      #1;
      chk("full_a_rdy", 32'(a_rdy), 0);
      chk("full_b_rdy", 32'(b_rdy), 0);
      chk("full_head", req_msg, 32'h00010010);
      req_rdy = 1;
      tick;
      req_rdy = 0;
      chk("full_deq_count", 32'(count), 3);
      chk("full_deq_head", req_msg, 32'h00020011);
      chk("full_a_rdy2", 32'(a_rdy), 1);
      tick;
      a_val = 0; b_val = 0;
      chk("full_refill", 32'(count), 4);
      req_rdy = 1;
      for (int k = 1; k < 5; k++) begin
         chk("full_drain_msg", req_msg, {16'(k + 1), 16'(k + 16)});
         chk("full_drain_last", 32'(req_last), 32'(k == 3));
         tick;
      end
      chk("full_drained", 32'(count), 0);
      chk("full_groups", 32'(groups_sent), 1);
      // simultaneous enq/deq at count 2
      do_reset;
      for (int k = 0; k < 2; k++) begin
         a_val = 1; b_val = 1; a_msg = 16'(k + 32); b_msg = 16'(k + 64);
         tick;
      end
      chk("sim_count0", 32'(count), 2);
      req_rdy = 1;
      for (int c = 0; c < 10; c++) begin
         a_msg = 16'(c + 34); b_msg = 16'(c + 66);
         tick;
         chk("sim_count", 32'(count), 2);
         chk("sim_msg", req_msg, {16'(c + 33), 16'(c + 65)});
      end
      a_val = 0; b_val = 0;
      tick;
      chk("sim_tail", req_msg, {16'(43), 16'(75)});
      tick;
      chk("sim_drained", 32'(count), 0);
      chk("sim_groups", 32'(groups_sent), 3);
      // reset mid-group
      do_reset;
      req_rdy = 1;
      for (int k = 0; k < 2; k++) begin
         a_val = 1; b_val = 1; a_msg = 16'(k + 256); b_msg = 16'(k + 512);
         tick;
      end
      reset = 0;
      #1;
      chk_zero("mid_rst");
      tick;
      chk_zero("mid_rst_held");
      reset = 1; a_val = 0; b_val = 0;
      #1;
      chk("mid_rel_count", 32'(count), 0);
      chk("mid_rel_val", 32'(req_val), 0);
      for (int k = 0; k < 4; k++) begin
         a_val = 1; b_val = 1; a_msg = 16'(k + 768); b_msg = 16'(k + 1024);
         tick;
         chk("mid_msg", req_msg, {16'(k + 768), 16'(k + 1024)});
         chk("mid_last", 32'(req_last), 32'(k == 3));
      end
      a_val = 0; b_val = 0;
      tick;
      chk("mid_groups", 32'(groups_sent), 1);
      // random throttling against a scoreboard
      do_reset;
      sent = 0; recv = 0; cyc = 0;
      while (recv < 400 && cyc < 20000) begin
         a_val = sent < 400 && $urandom_range(0, 3) != 0;
         b_val = sent < 400 && $urandom_range(0, 3) != 0;
         a_msg = 16'($urandom);
         b_msg = 16'($urandom);
         req_rdy = $urandom_range(0, 2) != 0;
         #1;
         sz = q.size();
         fire = a_val && b_val && sz < 4;
         chk("rnd_a_rdy", 32'(a_rdy), 32'(b_val && sz < 4));
         chk("rnd_b_rdy", 32'(b_rdy), 32'(a_val && sz < 4));
         chk("rnd_req_val", 32'(req_val), 32'(sz != 0));
         if (req_rdy && sz != 0) begin
            e = q.pop_front();
            chk("rnd_msg", req_msg, e[31:0]);
            chk("rnd_last", 32'(req_last), 32'(e[32]));
            recv++;
         end
         if (fire) begin
            q.push_back({sent % 4 == 3, a_msg, b_msg});
            sent++;
         end
         tick;
         cyc++;
      end
      a_val = 0; b_val = 0; req_rdy = 0;
      chk("rnd_recv", 32'(recv), 400);
      chk("rnd_groups", 32'(groups_sent), 100);
      chk("rnd_count", 32'(count), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
